field_loader: RTL and testbench
===============================

Name: field_loader

Overview:
- Sequences the combinational configuration ROM (`field_rom`) to copy an initial pattern into the live field memory before simulation starts.
- Also clears the field to all-dead on request.
- Walks every cell in row-major order and drives a ready/valid-style write port into the field RAM.
- While `o_busy` is high, the loader owns the field RAM; the generation-step engine must hold off.

Parameters:
- FIELD_W, 64, field width in cells (need not be a power of two).
- FIELD_H, 48, field height in cells (need not be a power of two).
- CONFIG_ID, 0, configuration index passed to the instantiated `field_rom`.
- X_ADR_SIZE, $clog2(FIELD_W), localparam, x address width.
- Y_ADR_SIZE, $clog2(FIELD_H), localparam, y address width.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- i_clear  in  1  sampled with i_start: 1 writes 0 to every cell, 0 copies ROM contents.
- o_busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- o_done  out  1  single-cycle pulse once the final cell write is accepted.
- o_wr_en  out  1  write request to field RAM.
- i_wr_ready  in  1  field RAM accepts the write this cycle when o_wr_en=1.
- o_wr_x  out  X_ADR_SIZE  cell x address of the current write.
- o_wr_y  out  Y_ADR_SIZE  cell y address of the current write.
- o_wr_data  out  1  cell state to write.

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE, x=y=0, clear flag=0. o_busy, o_done, o_wr_en, o_wr_data=0. o_wr_x, o_wr_y=0.
- FSM states: IDLE, SWEEP, DONE.
- IDLE: if i_start=1, latch i_clear, set x=y=0, go to SWEEP next cycle. Otherwise stay.
- SWEEP: o_wr_en=1, o_wr_x=x, o_wr_y=y.
  - ROM is addressed directly from x, y. Its output is combinational, so o_wr_data = clear_flag ? 0 : rom_out in the same cycle (zero latency).
- Handshake: a write is accepted when o_wr_en && i_wr_ready. On acceptance the counters advance:
  - If x=FIELD_W-1: x wraps to 0, y increments. Otherwise x increments.
  - If x=FIELD_W-1 and y=FIELD_H-1: go to DONE.
  - With i_wr_ready=0, address and data hold stable; no counter advance.
- DONE: o_done=1, o_wr_en=0, o_busy=1 for exactly one cycle, then IDLE.
- o_busy=1 in SWEEP and DONE; 0 in IDLE.
- Total accepted writes per sweep is exactly FIELD_W*FIELD_H, each cell exactly once, in row-major order.
- With i_wr_ready held at 1, the sweep takes FIELD_W*FIELD_H cycles in SWEEP, and o_done fires on the cycle after the last write.
- i_start while in SWEEP or DONE is ignored (not queued). i_clear has no effect outside IDLE-start.
- Reset asserted mid-sweep aborts immediately to IDLE with no o_done. Partially written RAM contents are not restored.
- Counter compares use FIELD_W-1 and FIELD_H-1 explicitly; addresses never exceed the field bounds.

Decomposition:
- Shared package `gol_pkg`:
  - `loader_state_t` enum {IDLE, SWEEP, DONE}.
  - Default FIELD_W/FIELD_H constants shared with the field RAM and step engine.
- Sub-module: one instance of `field_rom` (FIELD_W, FIELD_H, CONFIG_ID forwarded), addressed by the loader's x/y counters.
- Everything else (FSM, counters) lives in `field_loader`.

Test Plan:
- FIELD_W=4, FIELD_H=3, i_wr_ready=1, i_start=1, i_clear=0:
  - Expect 12 writes, addresses (0,0),(1,0)..(3,2) in row-major order.
  - o_wr_data matches the ROM file bit per cell.
  - o_done pulses on cycle 13 after start acceptance.
- Same setup with i_clear=1: 12 writes, all o_wr_data=0; o_done single pulse.
- Backpressure: i_wr_ready pseudo-random 50%. Expect address and data stable while stalled, still exactly 12 accepted writes, no duplicates or skips.
- FIELD_W=5, FIELD_H=3 (non-power-of-two): x wraps 4->0; no write with x>4 or y>2; 15 writes total.
- i_start pulsed during SWEEP and during DONE: ignored. Exactly one o_done, and o_busy falls the cycle after DONE.
- i_rst_n low at write 6: all outputs 0 asynchronously, state IDLE, no o_done. A new i_start afterwards restarts at (0,0) and completes 12 writes.

Source files
------------

// File: rtl/gol_pkg.sv
// ---------------------------------------------------------------------------
// gol_pkg
// Shared definitions for the Game-of-Life field datapath: the default field
// geometry used by the field RAM, the step engine and the loader, and the
// loader's FSM state type.
// ---------------------------------------------------------------------------
package gol_pkg;

   // Default field geometry shared by every block that touches the field RAM.
   localparam int DEF_FIELD_W = 64;
   localparam int DEF_FIELD_H = 48;

   // Loader sequencing states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } loader_state_t;

   // Address width for a dimension of n cells; never narrower than one bit,
   // so a degenerate one-cell dimension still has a legal port.
   function automatic int adr_size(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/field_rom.sv
// ---------------------------------------------------------------------------
// field_rom
// Combinational configuration ROM holding the initial field patterns. The
// cell state is a pure function of (x, y) and CONFIG_ID; no clock, zero
// latency.
//
// Patterns:
//   CONFIG_ID 0 : a single glider anchored at the top-left corner
//                 (row 0: .#.  row 1: ..#  row 2: ###); all other cells dead.
//   CONFIG_ID 1 : checkerboard, cell alive when x+y is odd.
//   other       : all cells dead.
//
// Ports:
//   x_i    in  X_ADR_SIZE  cell x address
//   y_i    in  Y_ADR_SIZE  cell y address
//   data_o out 1           cell state (1 = alive)
// ---------------------------------------------------------------------------
import gol_pkg::*;

module field_rom #(
   parameter int FIELD_W   = DEF_FIELD_W,
   parameter int FIELD_H   = DEF_FIELD_H,
   parameter int CONFIG_ID = 0,
   localparam int X_ADR_SIZE = adr_size(FIELD_W),
   localparam int Y_ADR_SIZE = adr_size(FIELD_H)
) (
   input  logic [X_ADR_SIZE-1:0] x_i,
   input  logic [Y_ADR_SIZE-1:0] y_i,
   output logic                  data_o
);

   // Glider bitmap, bit index = y*3 + x inside its 3x3 bounding box.
   localparam logic [8:0] GLIDER = 9'b111_100_010;

   logic [31:0] x_ext;
   logic [31:0] y_ext;
   logic [31:0] glider_idx;

   // Widen the addresses so the bounding-box compare is independent of the
   // field geometry (a 3 would truncate in a 1-bit address).
   assign x_ext      = {{(32-X_ADR_SIZE){1'b0}}, x_i};
   assign y_ext      = {{(32-Y_ADR_SIZE){1'b0}}, y_i};
   assign glider_idx = (y_ext * 32'd3) + x_ext;

   always_comb begin
      data_o = 1'b0;
      case (CONFIG_ID)
         0: begin
            if ((x_ext < 32'd3) && (y_ext < 32'd3)) begin
               data_o = GLIDER[glider_idx[3:0]];
            end
         end
         1: begin
            data_o = x_i[0] ^ y_i[0];
         end
         default: begin
            data_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/field_loader.sv
// ---------------------------------------------------------------------------
// field_loader
// Walks every cell of the field in row-major order and writes it into the
// field RAM through a valid/ready write port, either copying the pattern
// from field_rom or clearing the cell to dead. While o_busy is high the
// loader owns the field RAM.
//
// Ports:
//   i_clk      in  1           system clock, rising edge
//   i_rst_n    in  1           asynchronous active-low reset
//   i_start    in  1           sweep request, sampled only while idle
//   i_clear    in  1           sampled with i_start: 1 = clear, 0 = copy ROM
//   o_busy     out 1           loader owns the field RAM
//   o_done     out 1           one-cycle pulse after the final write
//   o_wr_en    out 1           write request
//   i_wr_ready in  1           RAM accepts the write this cycle
//   o_wr_x     out X_ADR_SIZE  cell x address
//   o_wr_y     out Y_ADR_SIZE  cell y address
//   o_wr_data  out 1           cell state to write
// ---------------------------------------------------------------------------
import gol_pkg::*;

module field_loader #(
   parameter int FIELD_W   = DEF_FIELD_W,
   parameter int FIELD_H   = DEF_FIELD_H,
   parameter int CONFIG_ID = 0,
   localparam int X_ADR_SIZE = adr_size(FIELD_W),
   localparam int Y_ADR_SIZE = adr_size(FIELD_H)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic                  i_clear,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_wr_en,
   input  logic                  i_wr_ready,
   output logic [X_ADR_SIZE-1:0] o_wr_x,
   output logic [Y_ADR_SIZE-1:0] o_wr_y,
   output logic                  o_wr_data
);

   localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - 1);
   localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);

   loader_state_t         state_q, state_d;
   logic [X_ADR_SIZE-1:0] x_q, x_d;
   logic [Y_ADR_SIZE-1:0] y_q, y_d;
   logic                  clear_q, clear_d;

   logic rom_data;
   logic wr_en;
   logic wr_accept;
   logic x_last;
   logic y_last;

   field_rom #(
      .FIELD_W  (FIELD_W),
      .FIELD_H  (FIELD_H),
      .CONFIG_ID(CONFIG_ID)
   ) u_rom (
      .x_i   (x_q),
      .y_i   (y_q),
      .data_o(rom_data)
   );

   assign wr_en     = (state_q == SWEEP);
   assign wr_accept = wr_en && i_wr_ready;
   assign x_last    = (x_q == X_LAST);
   assign y_last    = (y_q == Y_LAST);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         clear_q <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         clear_q <= clear_d;
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      clear_d = clear_q;
      unique case (state_q)
         IDLE: begin
            if (i_start) begin
               clear_d = i_clear;
               x_d     = '0;
               y_d     = '0;
               state_d = SWEEP;
            end
         end
         SWEEP: begin
            // Counters only move on an accepted write, so a stalled RAM sees
            // a stable address and data.
            if (wr_accept) begin
               if (x_last) begin
                  x_d = '0;
                  if (y_last) begin
                     // Park at the origin rather than stepping y past the
                     // last row.
                     y_d     = '0;
                     state_d = DONE;
                  end else begin
                     y_d = y_q + Y_ADR_SIZE'(1);
                  end
               end else begin
                  x_d = x_q + X_ADR_SIZE'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // All outputs decode straight from registered state, so they drop to
   // zero as soon as reset is asserted.
   assign o_busy    = (state_q != IDLE);
   assign o_done    = (state_q == DONE);
   assign o_wr_en   = wr_en;
   assign o_wr_x    = x_q;
   assign o_wr_y    = y_q;
   assign o_wr_data = wr_en && !clear_q && rom_data;

endmodule

// File: tb/tb_field_loader.sv
module tb_field_loader;

   localparam int W0 = 4;
   localparam int H0 = 3;
   localparam int W1 = 5;
   localparam int H1 = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic clr   = 1'b0;
   logic rdy   = 1'b1;

   logic       busy0, done0, we0, d0;
   logic [1:0] x0, y0;
   logic       busy1, done1, we1, d1;
   logic [2:0] x1;
   logic [1:0] y1;

   always #5 clk = ~clk;

   field_loader #(.FIELD_W(W0), .FIELD_H(H0), .CONFIG_ID(0)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_clear(clr),
      .o_busy(busy0), .o_done(done0), .o_wr_en(we0), .i_wr_ready(rdy),
      .o_wr_x(x0), .o_wr_y(y0), .o_wr_data(d0)
   );

   field_loader #(.FIELD_W(W1), .FIELD_H(H1), .CONFIG_ID(1)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_clear(clr),
      .o_busy(busy1), .o_done(done1), .o_wr_en(we1), .i_wr_ready(rdy),
      .o_wr_x(x1), .o_wr_y(y1), .o_wr_data(d1)
   );

   typedef struct {
      int x;
      int y;
      bit d;
   } wr_t;

   int  vectors     = 0;
   int  miscompares = 0;
   wr_t q[2][$];
   int  acc[2];
   int  dones[2];
   int  done_cyc[2];
   bit  pend[2];
   bit  stall[2];
   int  hx[2], hy[2];
   bit  hd[2];
   bit  prev_done[2];
   int  cyc       = 0;
   int  start_cyc = 0;
   bit  rand_rdy  = 1'b0;

   // Reference pattern: glider cell list for config 0, parity rule for 1.
   function automatic bit model_cell(int cfg, int x, int y);
      int gx[5] = '{1, 2, 0, 1, 2};
      int gy[5] = '{0, 1, 2, 2, 2};
      if (cfg == 0) begin
         for (int k = 0; k < 5; k++) if (gx[k] == x && gy[k] == y) return 1'b1;
         return 1'b0;
      end
      if (cfg == 1) return ((x + y) % 2) == 1;
      return 1'b0;
   endfunction

   task automatic check(string name, int act, int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic mon(int i, int fw, int fh, bit busy, bit done, bit we, int x, int y, bit d);
      wr_t e;
      if (!rst_n) begin
         stall[i]     = 1'b0;
         prev_done[i] = 1'b0;
         return;
      end
      if (we || done) check($sformatf("busy_active%0d", i), busy, 1);
      if (prev_done[i]) begin
         check($sformatf("busy_after_done%0d", i), busy, 0);
         check($sformatf("done_single%0d", i), done, 0);
      end
      if (we) begin
         check($sformatf("wr_in_bounds%0d", i), (x < fw && y < fh), 1);
         check($sformatf("no_wr_in_done%0d", i), done, 0);
      end
      if (stall[i]) begin
         check($sformatf("stall_held%0d", i), we, 1);
         check($sformatf("stall_x%0d", i), x, hx[i]);
         check($sformatf("stall_y%0d", i), y, hy[i]);
         check($sformatf("stall_d%0d", i), d, hd[i]);
      end
      if (we && rdy) begin
         if (q[i].size() == 0) begin
            check($sformatf("unexpected_write%0d", i), 1, 0);
         end else begin
            e = q[i].pop_front();
            check($sformatf("wr_x%0d", i), x, e.x);
            check($sformatf("wr_y%0d", i), y, e.y);
            check($sformatf("wr_data%0d(%0d,%0d)", i, e.x, e.y), d, e.d);
         end
         acc[i]++;
      end
      stall[i] = we && !rdy;
      hx[i] = x;
      hy[i] = y;
      hd[i] = d;
      if (done) begin
         check($sformatf("done_after_all_writes%0d", i), q[i].size(), 0);
         check($sformatf("done_expected%0d", i), pend[i], 1);
         pend[i] = 1'b0;
         dones[i]++;
         done_cyc[i] = cyc;
      end
      prev_done[i] = done;
   endtask

   always @(negedge clk) begin
      cyc++;
      mon(0, W0, H0, busy0, done0, we0, int'(x0), int'(y0), d0);
      mon(1, W1, H1, busy1, done1, we1, int'(x1), int'(y1), d1);
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         rdy = rand_rdy ? 1'($urandom % 2) : 1'b1;
      end
   end

   task automatic push_sweep(int i, int fw, int fh, int cfg, bit c);
      wr_t e;
      for (int y = 0; y < fh; y++) begin
         for (int x = 0; x < fw; x++) begin
            e.x = x;
            e.y = y;
            e.d = c ? 1'b0 : model_cell(cfg, x, y);
            q[i].push_back(e);
         end
      end
      pend[i]  = 1'b1;
      acc[i]   = 0;
      dones[i] = 0;
   endtask

   task automatic start_sweep(bit c);
      @(negedge clk);
      start = 1'b1;
      clr   = c;
      @(posedge clk);
      push_sweep(0, W0, H0, 0, c);
      push_sweep(1, W1, H1, 1, c);
      start_cyc = cyc;
      #1;
      start = 1'b0;
      clr   = 1'($urandom % 2);
   endtask

   task automatic wait_done(int limit);
      for (int k = 0; k < limit && (pend[0] || pend[1]); k++) @(negedge clk);
      check("sweep_completed", int'(pend[0] || pend[1]), 0);
      repeat (3) @(negedge clk);
      check("writes0", acc[0], W0 * H0);
      check("writes1", acc[1], W1 * H1);
      check("dones0", dones[0], 1);
      check("dones1", dones[1], 1);
   endtask

   task automatic check_outputs_zero(string tag);
      check({tag, "_busy0"}, busy0, 0);
      check({tag, "_done0"}, done0, 0);
      check({tag, "_we0"}, we0, 0);
      check({tag, "_data0"}, d0, 0);
      check({tag, "_addr0"}, int'({x0, y0}), 0);
      check({tag, "_busy1"}, busy1, 0);
      check({tag, "_we1"}, we1, 0);
      check({tag, "_addr1"}, int'({x1, y1}), 0);
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Copy sweep at full rate, with latency to o_done
      start_sweep(1'b0);
      wait_done(100);
      check("done_latency0", done_cyc[0] - start_cyc, W0 * H0 + 1);
      check("done_latency1", done_cyc[1] - start_cyc, W1 * H1 + 1);

      // Clear sweep at full rate
      start_sweep(1'b1);
      wait_done(100);

      // Random backpressure, copy then clear
      rand_rdy = 1'b1;
      start_sweep(1'b0);
      wait_done(500);
      start_sweep(1'b1);
      wait_done(500);
      rand_rdy = 1'b0;

      // Start pulses during SWEEP and DONE must be ignored
      start_sweep(1'b0);
      repeat (4) @(negedge clk);
      start = 1'b1;
      clr   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 0; k < 100 && !done0; k++) @(negedge clk);
      check("done0_seen", done0, 1);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(100);
      repeat (5) @(negedge clk);
      check("no_restart0", int'(busy0), 0);
      check("no_restart1", int'(busy1), 0);

      // Reset in the middle of a sweep
      start_sweep(1'b0);
      for (int k = 0; k < 100 && acc[0] < 6; k++) begin
         @(posedge clk);
         #2;
      end
      check("reached_write6", acc[0], 6);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midreset");
      q[0].delete();
      q[1].delete();
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      repeat (3) @(negedge clk);
      check("no_done_on_abort0", dones[0], 0);
      check("no_done_on_abort1", dones[1], 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      start_sweep(1'b0);
      wait_done(100);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
